gate_op_arbiter: RTL and testbench

// Shares one pipelined gate-primitive evaluator (NOT/OR/AND/XOR) between N

---
 rtl/gate_op_arbiter.sv | 113 +++++++++++
 tb/tb_gate_op_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_arbiter.sv
// Round-robin front end for one shared pipelined gate evaluator (NOT/OR/AND/XOR).
// Results leave in issue order, tagged with the requester index.

module gate_op_lane #(
  parameter int W = 8
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  always_comb begin
    case (op)
      2'd0:    y = ~a;
      2'd1:    y = a | b;
      2'd2:    y = a & b;
      default: y = a ^ b;
    endcase
  end
endmodule

module gate_op_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  input  logic [N-1:0][1:0]      req_op,
  input  logic [N-1:0][W-1:0]    req_a,
  input  logic [N-1:0][W-1:0]    req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [$clog2(N)-1:0]   rsp_id,
  output logic [W-1:0]           rsp_data,
  output logic                   busy
);
  localparam int IW = $clog2(N);

  logic [N-1:0][W-1:0]   lane_y;
  logic [LAT-1:0]        vld_pipe;
  logic [LAT-1:0][W-1:0] dat_pipe;
  logic [LAT-1:0][IW-1:0] id_pipe;
  logic [IW-1:0]         ptr;
  logic [N-1:0]          gnt;
  logic [IW-1:0]         gnt_id;
  logic                  gnt_any;
  logic                  stall;
  int                    idx;

  // Every requester's result is evaluated in parallel; the winner's is captured.
  for (genvar i = 0; i < N; i++) begin : g_lane
    gate_op_lane #(.W(W)) u_lane (
      .op (req_op[i]),
      .a  (req_a[i]),
      .b  (req_b[i]),
      .y  (lane_y[i])
    );
  end

  assign stall = vld_pipe[LAT-1] && !rsp_ready;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any     = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = IW'(idx);
      end
    end
    if (stall || rst) begin
      gnt     = '0;
      gnt_any = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      id_pipe  <= '0;
      ptr      <= '0;
    end else if (!stall) begin
      vld_pipe[0] <= gnt_any;
      if (gnt_any) begin
        dat_pipe[0] <= lane_y[gnt_id];
        id_pipe[0]  <= gnt_id;
        ptr         <= (gnt_id == IW'(N-1)) ? '0 : gnt_id + IW'(1);
      end
      // Payload only moves behind a valid op so the output holds its last result.
      for (int s = 1; s < LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) begin
          dat_pipe[s] <= dat_pipe[s-1];
          id_pipe[s]  <= id_pipe[s-1];
        end
      end
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = vld_pipe[LAT-1];
  assign rsp_data  = dat_pipe[LAT-1];
  assign rsp_id    = id_pipe[LAT-1];
  assign busy      = |vld_pipe;
endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed vectors plus a cycle-level reference model for gate_op_arbiter.
module tb_gate_op_arbiter;
  localparam int N = 4, W = 8, LAT = 2, IW = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0][1:0]   req_op;
  logic [N-1:0][W-1:0] req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [IW-1:0]       rsp_id;
  logic [W-1:0]        rsp_data;
  logic                busy;

  always #5 clk = ~clk;

  gate_op_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  int total = 0, bad = 0;

  logic [LAT-1:0] mv;
  logic [W-1:0]   md [LAT];
  logic [IW-1:0]  mi [LAT];
  int             mptr;
  int             last_g;
  int             wait_cnt [N];

  typedef struct {
    int         id;
    logic [1:0] op;
    logic [W-1:0] a, b, y;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gate_ref(input logic [1:0] op, input logic [W-1:0] a, b);
    case (op)
      2'd0:    return ~a;
      2'd1:    return a | b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model_clear();
    mv = '0;
    for (int s = 0; s < LAT; s++) begin md[s] = '0; mi[s] = '0; end
    mptr = 0;
    last_g = -1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // One clock: inputs are already set; checks grant, steps model, checks outputs.
  task automatic cycle();
    int g, idx;
    logic ms;
    logic [N-1:0] eg;
    logic [W-1:0] nd;
    #1;
    ms = mv[LAT-1] && !rsp_ready;
    g = -1;
    nd = '0;
    if (!ms)
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    eg = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      nd = gate_ref(req_op[g], req_a[g], req_b[g]);
    end
    chk("req_ready", req_ready, eg);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i]) wait_cnt[i] = 0;
      else if (!ms) begin
        wait_cnt[i]++;
        if (g == i) begin
          chk("wait_bound", wait_cnt[i] <= N, 1);
          wait_cnt[i] = 0;
        end
      end
    end
    last_g = g;
    @(posedge clk);
    if (!ms) begin
      for (int s = LAT-1; s > 0; s--) begin
        if (mv[s-1]) begin md[s] = md[s-1]; mi[s] = mi[s-1]; end
        mv[s] = mv[s-1];
      end
      mv[0] = (g >= 0);
      if (g >= 0) begin
        md[0] = nd;
        mi[0] = IW'(g);
        mptr = (g + 1) % N;
      end
    end
    #1;
    chk("rsp_valid", rsp_valid, mv[LAT-1]);
    chk("busy", busy, |mv);
    chk("rsp_data", rsp_data, md[LAT-1]);
    chk("rsp_id", rsp_id, mi[LAT-1]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_req_ready_hold", req_ready, 0);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vt[0] = '{2, 2'd3, 8'hF0, 8'h3C, 8'hCC};
    vt[1] = '{1, 2'd0, 8'h0F, 8'hAA, 8'hF0};
    vt[2] = '{0, 2'd1, 8'hA0, 8'h05, 8'hA5};
    vt[3] = '{3, 2'd2, 8'hF0, 8'h3C, 8'h30};
    vt[4] = '{1, 2'd3, 8'hFF, 8'hFF, 8'h00};
    vt[5] = '{0, 2'd0, 8'h00, 8'h12, 8'hFF};
    vt[6] = '{3, 2'd1, 8'h00, 8'h00, 8'h00};
    vt[7] = '{2, 2'd2, 8'hFF, 8'h81, 8'h81};
    vt[8] = '{0, 2'd0, 8'h0F, 8'h55, 8'hF0};

    req_valid = '1; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #1;
    do_reset();
    req_valid = '0;

    // single ops: latency, data, id, operand sampling
    foreach (vt[v]) begin
      req_valid = '0;
      req_valid[vt[v].id] = 1'b1;
      req_op[vt[v].id] = vt[v].op;
      req_a[vt[v].id]  = vt[v].a;
      req_b[vt[v].id]  = vt[v].b;
      cycle();
      chk("vec_gnt", last_g, vt[v].id);
      chk("vec_lat1_empty", rsp_valid, 0);
      req_valid = '0;
      req_a[vt[v].id] = ~vt[v].a;
      req_b[vt[v].id] = ~vt[v].b;
      cycle();
      chk("vec_valid", rsp_valid, 1);
      chk("vec_data", rsp_data, vt[v].y);
      chk("vec_id", rsp_id, vt[v].id);
    end
    cycle();
    cycle();

    // all requesters valid: strict rotation, back-to-back responses
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_op[i] = 2'(i); req_a[i] = 8'h5A + 8'(i); req_b[i] = 8'h0F;
    end
    req_valid = '1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rr_gnt", last_g, i % 4);
      if (i >= 1) begin
        chk("rr_rsp_valid", rsp_valid, 1);
        chk("rr_rsp_id", rsp_id, (i - 1) % 4);
      end
    end
    req_valid = '0;
    cycle();
    cycle();

    // output stall with two ops in flight
    do_reset();
    req_valid = 4'b0001; req_op[0] = 2'd3; req_a[0] = 8'hF0; req_b[0] = 8'h3C;
    cycle();
    chk("st_gnt0", last_g, 0);
    req_valid = 4'b0010; req_op[1] = 2'd2; req_a[1] = 8'hF0; req_b[1] = 8'h3C;
    cycle();
    chk("st_gnt1", last_g, 1);
    chk("st_first_valid", rsp_valid, 1);
    rsp_ready = 1'b0;
    req_valid = '1;
    repeat (5) begin
      cycle();
      chk("st_no_gnt", last_g, -1);
      chk("st_valid", rsp_valid, 1);
      chk("st_id", rsp_id, 0);
      chk("st_data", rsp_data, 8'hCC);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    cycle();
    chk("rel_valid", rsp_valid, 1);
    chk("rel_id", rsp_id, 1);
    chk("rel_data", rsp_data, 8'h30);
    cycle();
    chk("rel_empty", rsp_valid, 0);
    chk("rel_data_hold", rsp_data, 8'h30);
    chk("rel_id_hold", rsp_id, 1);

    // pointer wrap 3 -> 0
    do_reset();
    req_valid = 4'b1000;
    cycle();
    chk("wrap_g3", last_g, 3);
    req_valid = 4'b1001;
    cycle();
    chk("wrap_g0", last_g, 0);
    req_valid = 4'b1000;
    cycle();
    chk("wrap_g3b", last_g, 3);
    req_valid = 4'b1001;
    cycle();
    chk("wrap_g0b", last_g, 0);
    req_valid = '0;
    cycle();
    cycle();

    // reset with two ops in flight
    do_reset();
    req_valid = 4'b0001; req_op[0] = 2'd0; req_a[0] = 8'h0F;
    cycle();
    req_valid = 4'b0010;
    cycle();
    chk("mrst_pre_valid", rsp_valid, 1);
    chk("mrst_pre_busy", busy, 1);
    req_valid = '0;
    do_reset();
    repeat (4) begin
      cycle();
      chk("mrst_no_rsp", rsp_valid, 0);
    end

    // random traffic against the model
    do_reset();
    req_valid = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i) req_valid[i] = 1'($urandom_range(0, 1));
        req_op[i] = 2'($urandom_range(0, 3));
        req_a[i]  = 8'($urandom_range(0, 255));
        req_b[i]  = 8'($urandom_range(0, 255));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) cycle();
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
